uart_wb_bridge: RTL and testbench
=================================

// Module: uart_wb_bridge
// PURPOSE
// Serial-to-Wishbone debug initiator: receives 8N1 command frames on rxd, performs one 32-bit Wishbone
// read or write on the memory_controller, returns a status/data reply on txd. Sits opposite a uart_0
// TX line; gives the bench/host RAM/ROM/peripheral access without the core.
// PARAMETERS
// CLOCK_FREQ_HZ   115200*32  CLK_I frequency in Hz
// BAUD_RATE       115200     serial bit rate; DIV = CLOCK_FREQ_HZ/BAUD_RATE clocks/bit (integer, >=4)
// TIMEOUT_CYCLES  1024       max cycles waiting for ACK_I before the access is aborted
// PORTS
// CLK_I   in   1   clock, all logic on rising edge
// RST_I   in   1   synchronous reset, active-high
// rxd     in   1   serial in, idle high, async (2-FF synchronised inside)
// txd     out  1   serial out, idle high
// CYC_O   out  1   Wishbone cycle
// STB_O   out  1   Wishbone strobe
// WE_O    out  1   1 = write
// SEL_O   out  4   byte lanes, always 4'hF during an access
// ADR_O   out  32  byte address, as received (no alignment applied)
// DAT_O   out  32  write data
// DAT_I   in   32  read data, valid with ACK_I
// ACK_I   in   1   responder acknowledge
// BEHAVIOUR
// - Reset: txd=1, CYC_O=STB_O=WE_O=0, SEL_O=0, ADR_O=0, DAT_O=0, FSM=IDLE, RX/TX idle, counters 0.
//   RST_I mid-frame or mid-access aborts immediately (CYC_O/STB_O drop next edge); no reply sent.
// - RX: falling edge on synchronised rxd -> wait DIV/2, start bit re-sampled; if 1, drop (glitch).
//   8 data bits LSB first sampled every DIV clocks at bit centre; stop bit sampled; stop=0 -> framing error.
// - TX: 1 start, 8 data LSB first, 1 stop, DIV clocks each; back-to-back bytes with no idle gap.
// - Frame: CMD, A0..A3 (addr LSB first), then for write D0..D3 (data LSB first).
//   CMD 8'h57 ('W') = write, 8'h52 ('R') = read; any other CMD -> reply 8'h15 (NAK), back to IDLE.
// - FSM: IDLE -(CMD byte)-> GET_ADDR -(4 bytes)-> [W: GET_DATA -(4 bytes)->] BUS -> SEND -> IDLE.
//   Framing error in any receive state -> discard partial frame, reply 8'h15, IDLE.
//   No inter-byte timeout; bytes arriving during BUS/SEND are ignored (not queued).
// - BUS: cycle after last frame byte, CYC_O=STB_O=1, WE_O=cmd, SEL_O=4'hF, ADR_O/DAT_O stable.
//   Held until ACK_I sampled 1; on that edge DAT_I captured (read), CYC_O=STB_O=WE_O=0, SEL_O=0.
//   ACK_I while CYC_O=0 ignored. Zero-wait responders (ACK same cycle as STB) supported.
//   Timeout counter counts cycles with STB_O=1 & ACK_I=0; reaching TIMEOUT_CYCLES drops CYC/STB,
//   reply 8'h15. ACK_I on the same edge as timeout wins (access completes normally).
// - SEND: write OK -> 8'h06 (ACK byte); read OK -> 4 bytes of DAT_I LSB first; error -> 8'h15.
//   First start bit begins the cycle after SEND entered; IDLE entered after last stop bit ends.
// - Exactly one Wishbone access per frame; never issues a second STB before reply completes.
// TESTING (DIV=32, BUSY_CYCLES=2 RAM at 32'h01000000 through memory_controller)
// 1 Write: 57 00 00 00 01 EF BE AD DE -> one cycle WE_O=1 ADR_O=32'h01000000 DAT_O=32'hDEADBEEF SEL_O=F; txd 06.
// 2 Read back: 52 00 00 00 01 -> one cycle WE_O=0, txd EF BE AD DE; CYC_O low after ACK edge.
// 3 Bad cmd 8'hA5 -> no CYC_O ever; txd 15; next valid 'R' frame still served.
// 4 Unmapped addr 32'hF0000000 (ACK_I never) -> CYC_O high exactly 1024 cycles; txd 15.
// 5 Stop bit forced 0 on A2 -> no bus cycle, txd 15; 1-clock low glitch on idle rxd -> ignored.
// 6 RST_I pulsed while STB_O=1 -> CYC_O/STB_O 0 next edge, txd stays 1, no reply.

Source files
------------

// File: rtl/uart_wb_bridge.sv
// Serial-to-Wishbone debug initiator.
// Receives 8N1 command frames on rxd, runs one 32-bit Wishbone read or write,
// then returns a status byte or the read data on txd.
module uart_wb_bridge #(
    parameter int CLOCK_FREQ_HZ  = 115200 * 32,
    parameter int BAUD_RATE      = 115200,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic        rxd,
    output logic        txd,
    output logic        CYC_O,
    output logic        STB_O,
    output logic        WE_O,
    output logic [3:0]  SEL_O,
    output logic [31:0] ADR_O,
    output logic [31:0] DAT_O,
    input  logic [31:0] DAT_I,
    input  logic        ACK_I
);

    localparam int DIV = CLOCK_FREQ_HZ / BAUD_RATE;
    localparam int CW  = $clog2(DIV) + 1;
    localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CW-1:0] BIT_END  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_END = CW'(DIV / 2 - 1);
    localparam logic [TW-1:0] TMO_END  = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] CMD_W   = 8'h57;
    localparam logic [7:0] CMD_R   = 8'h52;
    localparam logic [7:0] RPL_ACK = 8'h06;
    localparam logic [7:0] RPL_NAK = 8'h15;

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

    rx_state_e     rx_st_q;
    logic          rx_s1_q, rx_s2_q, rx_s3_q;
    logic [CW-1:0] rx_cnt_q;
    logic [2:0]    rx_bit_q;
    logic [7:0]    rx_sh_q;
    logic          rx_vld_q;
    logic          rx_ferr_q;

    // Synchronise rxd, find the start edge, sample each bit at its centre
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_s3_q   <= 1'b1;
            rx_st_q   <= RX_IDLE;
            rx_cnt_q  <= '0;
            rx_bit_q  <= '0;
            rx_sh_q   <= '0;
            rx_vld_q  <= 1'b0;
            rx_ferr_q <= 1'b0;
        end else begin
            rx_s1_q  <= rxd;
            rx_s2_q  <= rx_s1_q;
            rx_s3_q  <= rx_s2_q;
            rx_vld_q <= 1'b0;
            case (rx_st_q)
                RX_IDLE: begin
                    if (rx_s3_q && !rx_s2_q) begin
                        rx_st_q  <= RX_START;
                        rx_cnt_q <= '0;
                    end
                end
                RX_START: begin
                    if (rx_cnt_q == HALF_END) begin
                        // line back high at mid start bit means it was a glitch
                        rx_cnt_q <= '0;
                        rx_bit_q <= '0;
                        rx_st_q  <= rx_s2_q ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_q == BIT_END) begin
                        rx_cnt_q <= '0;
                        rx_sh_q  <= {rx_s2_q, rx_sh_q[7:1]};
                        rx_bit_q <= rx_bit_q + 3'd1;
                        if (rx_bit_q == 3'd7) rx_st_q <= RX_STOP;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CW'(1);
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_q == BIT_END) begin
                        rx_cnt_q  <= '0;
                        rx_vld_q  <= 1'b1;
                        rx_ferr_q <= !rx_s2_q;
                        rx_st_q   <= RX_IDLE;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CW'(1);
                    end
                end
                default: rx_st_q <= RX_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Control FSM and Wishbone master
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_BUS, S_SEND} state_e;

    state_e        state_q;
    logic [1:0]    idx_q;
    logic          is_wr_q;
    logic [31:0]   adr_q, dat_q;
    logic          cyc_q, stb_q, we_q;
    logic [3:0]    sel_q;
    logic [TW-1:0] tmo_q;
    logic [31:0]   rpl_buf_q;
    logic [1:0]    rpl_more_q;
    logic          tx_go_q;
    logic          tx_last;

    // Frame assembly, single bus access, reply selection
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            is_wr_q    <= 1'b0;
            adr_q      <= '0;
            dat_q      <= '0;
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            we_q       <= 1'b0;
            sel_q      <= '0;
            tmo_q      <= '0;
            rpl_buf_q  <= '0;
            rpl_more_q <= '0;
            tx_go_q    <= 1'b0;
        end else begin
            tx_go_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (rx_vld_q) begin
                        if (!rx_ferr_q && (rx_sh_q == CMD_W || rx_sh_q == CMD_R)) begin
                            is_wr_q <= (rx_sh_q == CMD_W);
                            idx_q   <= '0;
                            state_q <= S_ADDR;
                        end else begin
                            rpl_buf_q  <= {24'h0, RPL_NAK};
                            rpl_more_q <= '0;
                            tx_go_q    <= 1'b1;
                            state_q    <= S_SEND;
                        end
                    end
                end
                S_ADDR, S_DATA: begin
                    if (rx_vld_q) begin
                        if (rx_ferr_q) begin
                            rpl_buf_q  <= {24'h0, RPL_NAK};
                            rpl_more_q <= '0;
                            tx_go_q    <= 1'b1;
                            state_q    <= S_SEND;
                        end else begin
                            if (state_q == S_ADDR) adr_q[{idx_q, 3'b000} +: 8] <= rx_sh_q;
                            else                   dat_q[{idx_q, 3'b000} +: 8] <= rx_sh_q;
                            idx_q <= idx_q + 2'd1;
                            if (idx_q == 2'd3) begin
                                if (state_q == S_ADDR && is_wr_q) begin
                                    state_q <= S_DATA;
                                end else begin
                                    cyc_q   <= 1'b1;
                                    stb_q   <= 1'b1;
                                    we_q    <= is_wr_q;
                                    sel_q   <= 4'hF;
                                    tmo_q   <= '0;
                                    state_q <= S_BUS;
                                end
                            end
                        end
                    end
                end
                S_BUS: begin
                    // ACK takes priority over a timeout landing on the same edge
                    if (ACK_I) begin
                        cyc_q      <= 1'b0;
                        stb_q      <= 1'b0;
                        we_q       <= 1'b0;
                        sel_q      <= '0;
                        rpl_buf_q  <= is_wr_q ? {24'h0, RPL_ACK} : DAT_I;
                        rpl_more_q <= is_wr_q ? 2'd0 : 2'd3;
                        tx_go_q    <= 1'b1;
                        state_q    <= S_SEND;
                    end else if (tmo_q == TMO_END) begin
                        cyc_q      <= 1'b0;
                        stb_q      <= 1'b0;
                        we_q       <= 1'b0;
                        sel_q      <= '0;
                        rpl_buf_q  <= {24'h0, RPL_NAK};
                        rpl_more_q <= '0;
                        tx_go_q    <= 1'b1;
                        state_q    <= S_SEND;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                S_SEND: begin
                    if (tx_last) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Transmitter: 1..4 reply bytes sent back to back
    // ------------------------------------------------------------------
    logic          txd_q;
    logic          tx_busy_q;
    logic [CW-1:0] tx_cnt_q;
    logic [3:0]    tx_idx_q;
    logic [9:0]    tx_frm_q;
    logic [23:0]   tx_rest_q;
    logic [1:0]    tx_left_q;
    logic          tx_bit_end;

    assign tx_bit_end = tx_busy_q && (tx_cnt_q == BIT_END);
    assign tx_last    = tx_bit_end && (tx_idx_q == 4'd9) && (tx_left_q == 2'd0);

    // Shift out {stop, data, start}; the next byte's start follows the stop directly
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            txd_q     <= 1'b1;
            tx_busy_q <= 1'b0;
            tx_cnt_q  <= '0;
            tx_idx_q  <= '0;
            tx_frm_q  <= '1;
            tx_rest_q <= '0;
            tx_left_q <= '0;
        end else if (tx_go_q) begin
            tx_busy_q <= 1'b1;
            tx_cnt_q  <= '0;
            tx_idx_q  <= '0;
            tx_frm_q  <= {1'b1, rpl_buf_q[7:0], 1'b0};
            tx_rest_q <= rpl_buf_q[31:8];
            tx_left_q <= rpl_more_q;
            txd_q     <= 1'b0;
        end else if (tx_bit_end) begin
            tx_cnt_q <= '0;
            if (tx_idx_q == 4'd9) begin
                if (tx_left_q != 2'd0) begin
                    tx_idx_q  <= '0;
                    tx_frm_q  <= {1'b1, tx_rest_q[7:0], 1'b0};
                    tx_rest_q <= {8'h00, tx_rest_q[23:8]};
                    tx_left_q <= tx_left_q - 2'd1;
                    txd_q     <= 1'b0;
                end else begin
                    tx_busy_q <= 1'b0;
                    txd_q     <= 1'b1;
                end
            end else begin
                tx_idx_q <= tx_idx_q + 4'd1;
                tx_frm_q <= {1'b1, tx_frm_q[9:1]};
                txd_q    <= tx_frm_q[1];
            end
        end else if (tx_busy_q) begin
            tx_cnt_q <= tx_cnt_q + CW'(1);
        end
    end

    assign txd   = txd_q;
    assign CYC_O = cyc_q;
    assign STB_O = stb_q;
    assign WE_O  = we_q;
    assign SEL_O = sel_q;
    assign ADR_O = adr_q;
    assign DAT_O = dat_q;

endmodule

// File: tb/tb_uart_wb_bridge.sv
// Bench for uart_wb_bridge: host-side UART driver/monitor, RAM responder,
// and a frame-level reference model predicting bus activity and reply bytes.
module tb_uart_wb_bridge;

    localparam int DIV = 32;
    localparam int TMO = 1024;

    logic        clk = 1'b0;
    logic        rst, rxd, txd;
    logic        cyc, stb, we, ack;
    logic [3:0]  sel;
    logic [31:0] adr, dat_o, dat_i;

    uart_wb_bridge #(.CLOCK_FREQ_HZ(115200 * 32), .BAUD_RATE(115200), .TIMEOUT_CYCLES(TMO)) dut (
        .CLK_I(clk), .RST_I(rst), .rxd(rxd), .txd(txd),
        .CYC_O(cyc), .STB_O(stb), .WE_O(we), .SEL_O(sel),
        .ADR_O(adr), .DAT_O(dat_o), .DAT_I(dat_i), .ACK_I(ack)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0, cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc_n);
    endtask

    // Reference state shared between stimulus and the compare process
    logic [31:0] mdl_mem [logic [31:0]];
    logic [7:0]  exp_q[$], got_q[$], got_log[$];
    logic [31:0] exp_adr = '0, exp_dat = '0;
    logic        exp_we = 1'b0, bus_allowed = 1'b0, started = 1'b0;
    int          acc_cnt = 0, cur_len = 0, last_len = 0;
    logic        cyc_prev = 1'b0;

    // RAM responder at 32'h01000xxx; busy_n wait states, 0 = ACK with first STB cycle
    logic [31:0] ram [logic [31:0]];
    int busy_n = 2;
    initial begin
        int wcnt;
        wcnt = 0;
        ack = 1'b0;
        dat_i = '0;
        forever begin
            @(posedge clk);
            #1;
            if (cyc && stb && adr[31:12] == 20'h01000) begin
                if (wcnt == busy_n) begin
                    ack = 1'b1;
                    if (we) ram[adr] = dat_o;
                    dat_i = ram.exists(adr) ? ram[adr] : 32'h0;
                end else begin
                    wcnt++;
                    ack = 1'b0;
                end
            end else begin
                ack = 1'b0;
                wcnt = 0;
            end
        end
    end

    // Host-side UART receiver on txd; also checks back-to-back byte spacing
    initial begin
        logic       txd_prev;
        logic [7:0] b;
        int         last_start, st;
        txd_prev = 1'b1;
        last_start = -100000;
        forever begin
            @(negedge clk);
            if (!rst && txd_prev && !txd) begin
                st = cyc_n;
                if (st - last_start < 12 * DIV) chk("tx_gap", st - last_start, 10 * DIV);
                last_start = st;
                repeat (DIV / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (DIV) @(negedge clk);
                    b[i] = txd;
                end
                repeat (DIV) @(negedge clk);
                chk("tx_stop", {31'h0, txd}, 32'h1);
                got_q.push_back(b);
            end
            txd_prev = txd;
        end
    end

    // Compare process: bus outputs every cycle, reply bytes as they arrive
    always @(negedge clk) begin
        if (cyc && !cyc_prev) begin acc_cnt++; cur_len = 0; end
        if (cyc) cur_len++;
        if (!cyc && cyc_prev) last_len = cur_len;
        cyc_prev = cyc;
        if (!rst && started) begin
            if (cyc) begin
                chk("bus_allowed", {31'h0, bus_allowed}, 32'h1);
                chk("stb", {31'h0, stb}, 32'h1);
                chk("sel", {28'h0, sel}, 32'hF);
                chk("adr", adr, exp_adr);
                chk("we", {31'h0, we}, {31'h0, exp_we});
                if (exp_we) chk("dat_o", dat_o, exp_dat);
            end else begin
                chk("idle_bus", {26'h0, stb, we, sel}, 32'h0);
            end
        end
        while (got_q.size() > 0) begin
            logic [7:0] g;
            g = got_q.pop_front();
            got_log.push_back(g);
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL tx_unexpected: got %h expected no byte (cycle %0d)", g, cyc_n);
            end else begin
                chk("tx_byte", {24'h0, g}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stopv);
        rxd = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (DIV) @(negedge clk);
        end
        rxd = stopv;
        repeat (DIV) @(negedge clk);
        rxd = 1'b1;
    endtask

    // Frame-level model: decide access and reply, send the frame, await reply.
    // bad_idx >= 0: that byte has its stop bit forced low and the frame ends there.
    task automatic do_frame(input logic [7:0] cmd, input logic [31:0] addr,
                            input logic [31:0] data, input int bad_idx);
        logic [7:0]  fb[$];
        logic [7:0]  rp[$];
        logic [31:0] d;
        bit          acc, mapped, valid;
        int          a0, g0, w;
        valid = (cmd == 8'h57 || cmd == 8'h52);
        fb.push_back(cmd);
        if (valid) for (int i = 0; i < 4; i++) fb.push_back(addr[8*i +: 8]);
        if (cmd == 8'h57) for (int i = 0; i < 4; i++) fb.push_back(data[8*i +: 8]);
        acc = 1'b0;
        mapped = (addr[31:12] == 20'h01000);
        if (bad_idx >= 0) begin
            while (fb.size() > bad_idx + 1) void'(fb.pop_back());
            rp.push_back(8'h15);
        end else if (!valid) begin
            rp.push_back(8'h15);
        end else begin
            acc = 1'b1;
            if (!mapped) rp.push_back(8'h15);
            else if (cmd == 8'h57) begin
                mdl_mem[addr] = data;
                rp.push_back(8'h06);
            end else begin
                d = mdl_mem.exists(addr) ? mdl_mem[addr] : 32'h0;
                for (int i = 0; i < 4; i++) rp.push_back(d[8*i +: 8]);
            end
        end
        a0 = acc_cnt;
        g0 = got_log.size();
        exp_adr = addr;
        exp_we = (cmd == 8'h57);
        exp_dat = data;
        foreach (rp[i]) exp_q.push_back(rp[i]);
        for (int i = 0; i < fb.size(); i++) begin
            if (i == fb.size() - 1) bus_allowed = acc;
            send_byte(fb[i], (i == bad_idx) ? 1'b0 : 1'b1);
        end
        w = 0;
        while (got_log.size() < g0 + rp.size() && w < TMO + 60 * DIV) begin
            @(negedge clk);
            w++;
        end
        chk("reply_arrived", {31'h0, got_log.size() >= g0 + rp.size()}, 32'h1);
        repeat (2 * DIV) @(negedge clk);
        bus_allowed = 1'b0;
        chk("access_count", acc_cnt - a0, {31'h0, acc});
        if (acc && !mapped) chk("timeout_len", last_len, TMO);
        chk("exp_drained", exp_q.size(), 0);
    endtask

    function automatic logic [7:0] last_got(input int back);
        return got_log[got_log.size() - 1 - back];
    endfunction

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish expected finish before cycle 90000");
        $fatal(1, "watchdog");
    end

    initial begin
        int g0, a0, w;
        logic txd_low;
        rst = 1'b1;
        rxd = 1'b1;
        repeat (5) @(negedge clk);
        // reset values
        chk("rst_txd", {31'h0, txd}, 32'h1);
        chk("rst_cyc", {31'h0, cyc}, 32'h0);
        chk("rst_stb", {31'h0, stb}, 32'h0);
        chk("rst_we", {31'h0, we}, 32'h0);
        chk("rst_sel", {28'h0, sel}, 32'h0);
        chk("rst_adr", adr, 32'h0);
        chk("rst_dat", dat_o, 32'h0);
        rst = 1'b0;
        started = 1'b1;
        repeat (4 * DIV) @(negedge clk);

        // 1: write DEADBEEF
        do_frame(8'h57, 32'h0100_0000, 32'hDEAD_BEEF, -1);
        chk("t1_ack_lit", {24'h0, last_got(0)}, 32'h06);
        // 2: read back, bytes LSB first
        do_frame(8'h52, 32'h0100_0000, 32'h0, -1);
        chk("t2_b0_lit", {24'h0, last_got(3)}, 32'hEF);
        chk("t2_b1_lit", {24'h0, last_got(2)}, 32'hBE);
        chk("t2_b2_lit", {24'h0, last_got(1)}, 32'hAD);
        chk("t2_b3_lit", {24'h0, last_got(0)}, 32'hDE);
        // 3: bad command, then a valid read still served
        do_frame(8'hA5, 32'h0, 32'h0, -1);
        chk("t3_nak_lit", {24'h0, last_got(0)}, 32'h15);
        do_frame(8'h52, 32'h0100_0000, 32'h0, -1);
        // 4: unmapped address times out
        do_frame(8'h52, 32'hF000_0000, 32'h0, -1);
        chk("t4_nak_lit", {24'h0, last_got(0)}, 32'h15);
        chk("t4_len_lit", last_len, 32'd1024);
        // 5: framing error on A2, then a one-clock glitch on idle rxd
        do_frame(8'h52, 32'h0100_0004, 32'h0, 3);
        chk("t5_nak_lit", {24'h0, last_got(0)}, 32'h15);
        g0 = got_log.size();
        a0 = acc_cnt;
        rxd = 1'b0;
        @(negedge clk);
        rxd = 1'b1;
        repeat (3 * DIV) @(negedge clk);
        chk("glitch_no_reply", got_log.size(), g0);
        chk("glitch_no_access", acc_cnt, a0);
        do_frame(8'h57, 32'h0100_0004, 32'h1234_5678, -1);
        // zero-wait responder
        busy_n = 0;
        do_frame(8'h52, 32'h0100_0004, 32'h0, -1);
        chk("zw_b0_lit", {24'h0, last_got(3)}, 32'h78);
        chk("zw_b3_lit", {24'h0, last_got(0)}, 32'h12);
        do_frame(8'h57, 32'h0100_0008, 32'hCAFE_F00D, -1);
        do_frame(8'h52, 32'h0100_0008, 32'h0, -1);
        busy_n = 2;

        // 6: reset while STB_O is high aborts the access with no reply
        g0 = got_log.size();
        exp_adr = 32'hF000_0000;
        exp_we = 1'b0;
        send_byte(8'h52, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        bus_allowed = 1'b1;
        send_byte(8'h00, 1'b1);
        send_byte(8'hF0, 1'b1);
        w = 0;
        while (!stb && w < 4 * DIV) begin
            @(negedge clk);
            w++;
        end
        chk("t6_stb_seen", {31'h0, stb}, 32'h1);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_cyc_drop", {31'h0, cyc}, 32'h0);
        chk("t6_stb_drop", {31'h0, stb}, 32'h0);
        rst = 1'b0;
        bus_allowed = 1'b0;
        txd_low = 1'b0;
        repeat (15 * DIV) begin
            @(negedge clk);
            if (!txd) txd_low = 1'b1;
        end
        chk("t6_txd_idle", {31'h0, txd_low}, 32'h0);
        chk("t6_no_reply", got_log.size(), g0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
